warp_lsu: RTL and testbench

WARP_LSU -- requirements
Module: warp_lsu

---
 rtl/warp_lsu_pkg.sv | 34 +++
 rtl/warp_lsu_lane_select.sv | 23 ++
 rtl/warp_lsu.sv | 139 +++++++++++++
 tb/tb_warp_lsu.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/warp_lsu_pkg.sv
// Shared types and constants for the warp load/store unit.
// Address width is narrower than the data word, so addresses are truncated operands.
package warp_lsu_pkg;

  localparam int unsigned THREADS_PER_WARP_DEFAULT = 4;
  localparam int unsigned DATA_BITS                = 16;
  localparam int unsigned DATA_MEM_ADDR_BITS       = 8;

  typedef logic [DATA_BITS-1:0]          data_t;
  typedef logic [DATA_MEM_ADDR_BITS-1:0] data_memory_address_t;

  typedef enum logic [2:0] {
    WARP_IDLE,
    WARP_FETCH,
    WARP_DECODE,
    WARP_REQUEST,
    WARP_WAIT,
    WARP_EXECUTE,
    WARP_UPDATE,
    WARP_DONE
  } warp_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQUESTING,
    LSU_WAITING,
    LSU_DONE
  } lsu_state_t;

  function automatic data_memory_address_t to_mem_address(input data_t operand);
    return data_memory_address_t'(operand);
  endfunction

endpackage

// File: rtl/warp_lsu_lane_select.sv
// Lowest-set-bit selector: picks the lowest-index pending lane.
module lane_select #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned INDEX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]   mask,
  output logic [INDEX_W-1:0] index,
  output logic               any_valid
);

  // Scan from the top down so the lowest set bit is the last to write.
  always_comb begin
    index     = '0;
    any_valid = 1'b0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (mask[i-1]) begin
        index     = INDEX_W'(i - 1);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_lsu.sv
// Warp load/store unit: serialises per-lane memory requests, lowest lane first,
// optionally broadcasting one load response to every lane sharing its address.
module warp_lsu
  import warp_lsu_pkg::*;
#(
  parameter int unsigned THREADS_PER_WARP = THREADS_PER_WARP_DEFAULT,
  parameter bit          COALESCE_LOADS   = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  warp_state_t                 warp_state,
  input  logic                        decoded_mem_read_enable,
  input  logic                        decoded_mem_write_enable,
  input  logic [THREADS_PER_WARP-1:0] thread_mask,
  input  data_t                       rs1 [THREADS_PER_WARP],
  input  data_t                       rs2 [THREADS_PER_WARP],
  output logic                        mem_read_valid,
  output data_memory_address_t        mem_read_address,
  input  logic                        mem_read_ready,
  input  data_t                       mem_read_data,
  output logic                        mem_write_valid,
  output data_memory_address_t        mem_write_address,
  output data_t                       mem_write_data,
  input  logic                        mem_write_ready,
  output lsu_state_t                  lsu_state,
  output data_t                       lsu_out [THREADS_PER_WARP]
);

  localparam int unsigned LANE_W = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1;

  lsu_state_t                  state_next;
  logic [THREADS_PER_WARP-1:0] pending, pending_next;
  logic                        op_load, op_load_next;
  logic [LANE_W-1:0]           lane, lane_next;
  logic [LANE_W-1:0]           sel_lane;
  logic                        sel_any;
  logic                        read_valid_next, write_valid_next;
  data_memory_address_t        read_address_next, write_address_next;
  data_t                       write_data_next;
  data_t                       lsu_out_next [THREADS_PER_WARP];
  logic                        acked;

  lane_select #(
    .WIDTH   (THREADS_PER_WARP),
    .INDEX_W (LANE_W)
  ) u_lane_select (
    .mask      (pending),
    .index     (sel_lane),
    .any_valid (sel_any)
  );

  assign acked = op_load ? mem_read_ready : mem_write_ready;

  always_comb begin
    state_next         = lsu_state;
    pending_next       = pending;
    op_load_next       = op_load;
    lane_next          = lane;
    read_valid_next    = mem_read_valid;
    read_address_next  = mem_read_address;
    write_valid_next   = mem_write_valid;
    write_address_next = mem_write_address;
    write_data_next    = mem_write_data;
    lsu_out_next       = lsu_out;

    case (lsu_state)
      LSU_IDLE: begin
        if ((decoded_mem_read_enable || decoded_mem_write_enable) && warp_state == WARP_REQUEST) begin
          pending_next = thread_mask;
          op_load_next = decoded_mem_read_enable;
          state_next   = LSU_REQUESTING;
        end
      end
      LSU_REQUESTING: begin
        if (!sel_any) begin
          state_next = LSU_DONE;
        end else begin
          lane_next  = sel_lane;
          state_next = LSU_WAITING;
          if (op_load) begin
            read_valid_next   = 1'b1;
            read_address_next = to_mem_address(rs1[sel_lane]);
          end else begin
            write_valid_next   = 1'b1;
            write_address_next = to_mem_address(rs1[sel_lane]);
            write_data_next    = rs2[sel_lane];
          end
        end
      end
      LSU_WAITING: begin
        if (acked) begin
          read_valid_next  = 1'b0;
          write_valid_next = 1'b0;
          state_next       = LSU_REQUESTING;
          // Coalescing compares full operands, not truncated addresses.
          for (int unsigned i = 0; i < THREADS_PER_WARP; i++) begin
            if (pending[i] && (LANE_W'(i) == lane ||
                (COALESCE_LOADS && op_load && rs1[i] == rs1[lane]))) begin
              pending_next[i] = 1'b0;
              if (op_load) lsu_out_next[i] = mem_read_data;
            end
          end
        end
      end
      LSU_DONE: begin
        if (warp_state == WARP_UPDATE) state_next = LSU_IDLE;
      end
      default: state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lsu_state         <= LSU_IDLE;
      pending           <= '0;
      op_load           <= 1'b0;
      lane              <= '0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      for (int unsigned i = 0; i < THREADS_PER_WARP; i++) lsu_out[i] <= '0;
    end else if (enable) begin
      lsu_state         <= state_next;
      pending           <= pending_next;
      op_load           <= op_load_next;
      lane              <= lane_next;
      mem_read_valid    <= read_valid_next;
      mem_read_address  <= read_address_next;
      mem_write_valid   <= write_valid_next;
      mem_write_address <= write_address_next;
      mem_write_data    <= write_data_next;
      lsu_out           <= lsu_out_next;
    end
  end

endmodule

// File: tb/tb_warp_lsu.sv
// Randomised self-checking bench for warp_lsu against a request-queue reference model.
module tb_warp_lsu;
  import warp_lsu_pkg::*;

  localparam int unsigned T = 4;

  logic                 clk = 1'b0;
  logic                 reset, enable;
  warp_state_t          warp_state;
  logic                 decoded_mem_read_enable, decoded_mem_write_enable;
  logic [T-1:0]         thread_mask;
  data_t                rs1 [T];
  data_t                rs2 [T];
  logic                 mem_read_valid, mem_read_ready;
  data_memory_address_t mem_read_address;
  data_t                mem_read_data;
  logic                 mem_write_valid, mem_write_ready;
  data_memory_address_t mem_write_address;
  data_t                mem_write_data;
  lsu_state_t           lsu_state;
  data_t                lsu_out [T];

  always #5 clk = ~clk;

  warp_lsu #(
    .THREADS_PER_WARP (T),
    .COALESCE_LOADS   (1'b1)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .warp_state               (warp_state),
    .decoded_mem_read_enable  (decoded_mem_read_enable),
    .decoded_mem_write_enable (decoded_mem_write_enable),
    .thread_mask              (thread_mask),
    .rs1                      (rs1),
    .rs2                      (rs2),
    .mem_read_valid           (mem_read_valid),
    .mem_read_address         (mem_read_address),
    .mem_read_ready           (mem_read_ready),
    .mem_read_data            (mem_read_data),
    .mem_write_valid          (mem_write_valid),
    .mem_write_address        (mem_write_address),
    .mem_write_data           (mem_write_data),
    .mem_write_ready          (mem_write_ready),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out)
  );

  typedef struct {
    logic                 is_load;
    data_memory_address_t addr;
    data_t                wdata;
    logic [T-1:0]         lanes;
  } req_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  data_t       exp_out [T];
  data_t       salt;
  req_t        exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input data_t a0, a1, a2, a3, d0, d1, d2, d3);
    rs1[0] = a0; rs1[1] = a1; rs1[2] = a2; rs1[3] = a3;
    rs2[0] = d0; rs2[1] = d1; rs2[2] = d2; rs2[3] = d3;
  endtask

  // hold < 0: random ready delay per request; freeze: drop enable on first request.
  task automatic run_op(input logic [T-1:0] mask, input bit rd, input bit wr,
                        input int hold, input bit freeze);
    logic [T-1:0] pend, lanes;
    req_t         r;
    int           l, cyc, extra, nreq, wait_left;
    bit           is_load, froze;
    data_t        resp;

    is_load = rd;
    pend    = mask;
    exp_q.delete();
    while (pend != '0) begin
      l = 0;
      while (!pend[l]) l++;
      lanes = '0;
      for (int i = 0; i < T; i++)
        if (pend[i] && (i == l || (is_load && rs1[i] == rs1[l]))) lanes[i] = 1'b1;
      r.is_load = is_load;
      r.addr    = data_memory_address_t'(rs1[l]);
      r.wdata   = rs2[l];
      r.lanes   = lanes;
      exp_q.push_back(r);
      pend &= ~lanes;
    end
    nreq = exp_q.size();

    @(negedge clk);
    warp_state               = WARP_REQUEST;
    decoded_mem_read_enable  = rd;
    decoded_mem_write_enable = wr;
    thread_mask              = mask;
    @(posedge clk); #1;
    check("exit_idle", lsu_state, LSU_REQUESTING);
    warp_state = WARP_WAIT;

    cyc = 0; extra = 0; wait_left = -1; froze = 1'b0;
    while (lsu_state != LSU_DONE && cyc < 200) begin
      check("serial", {mem_read_valid, mem_write_valid} != 2'b11, 1);
      mem_read_data = data_t'($urandom);
      if (mem_read_valid || mem_write_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_request", 1, 0);
          mem_read_ready = 1'b1; mem_write_ready = 1'b1;
        end else begin
          r = exp_q[0];
          if (wait_left < 0) begin
            wait_left = (hold >= 0) ? hold : int'($urandom_range(0, 2));
            check("port_is_read", mem_read_valid, r.is_load);
            check("port_is_write", mem_write_valid, !r.is_load);
            if (!r.is_load) check("write_data", mem_write_data, r.wdata);
            if (freeze && !froze) begin
              froze  = 1'b1;
              enable = 1'b0;
              mem_read_ready = 1'b1; mem_write_ready = 1'b1;
              repeat (3) begin
                @(posedge clk); #1; cyc++; extra++;
                check("freeze_state", lsu_state, LSU_WAITING);
                check("freeze_valid", mem_read_valid | mem_write_valid, 1);
              end
              enable = 1'b1;
            end
          end
          check("address", r.is_load ? mem_read_address : mem_write_address, r.addr);
          if (wait_left == 0) begin
            resp = data_t'(r.addr) + 16'd100 + salt;
            mem_read_data   = resp;
            mem_read_ready  = r.is_load;
            mem_write_ready = !r.is_load;
            if (r.is_load)
              for (int i = 0; i < T; i++) if (r.lanes[i]) exp_out[i] = resp;
            void'(exp_q.pop_front());
            wait_left = -1;
          end else begin
            mem_read_ready = 1'b0; mem_write_ready = 1'b0;
            wait_left--;
            extra++;
          end
        end
      end else begin
        mem_read_ready = 1'b0; mem_write_ready = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_read_ready = 1'b0; mem_write_ready = 1'b0;

    check("cycles_to_done", cyc, 2 * nreq + 1 + extra);
    check("requests_left", exp_q.size(), 0);
    check("done_valids", {mem_read_valid, mem_write_valid}, 2'b00);
    for (int i = 0; i < T; i++) check($sformatf("lsu_out%0d", i), lsu_out[i], exp_out[i]);

    warp_state = WARP_UPDATE;
    @(posedge clk); #1;
    check("back_to_idle", lsu_state, LSU_IDLE);
    warp_state = WARP_IDLE;
    decoded_mem_read_enable = 1'b0; decoded_mem_write_enable = 1'b0;
  endtask

  task automatic reset_mid_wait();
    int budget;
    set_ops(16'd33, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    warp_state = WARP_REQUEST; decoded_mem_read_enable = 1'b1; thread_mask = 4'b0001;
    @(posedge clk); #1;
    warp_state = WARP_WAIT;
    mem_read_ready = 1'b0;
    budget = 0;
    while (!mem_read_valid && budget < 20) begin
      @(posedge clk); #1; budget++;
    end
    check("rst_valid_seen", mem_read_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_valid_drop", mem_read_valid, 0);
    check("rst_state", lsu_state, LSU_IDLE);
    mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
    repeat (2) @(posedge clk);
    #1;
    check("late_ready_state", lsu_state, LSU_IDLE);
    check("late_ready_valid", mem_read_valid, 0);
    check("late_ready_out0", lsu_out[0], 0);
    mem_read_ready = 1'b0;
    decoded_mem_read_enable = 1'b0;
    warp_state = WARP_IDLE;
    for (int i = 0; i < T; i++) exp_out[i] = '0;
  endtask

  initial begin
    data_t       pool [4];
    logic [T-1:0] m;
    bit          rd, wr;

    reset = 1'b1; enable = 1'b1; warp_state = WARP_IDLE;
    decoded_mem_read_enable = 1'b0; decoded_mem_write_enable = 1'b0;
    thread_mask = '0; mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
    set_ops(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    salt = '0;
    for (int i = 0; i < T; i++) exp_out[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", lsu_state, LSU_IDLE);
    check("reset_read_valid", mem_read_valid, 0);
    check("reset_write_valid", mem_write_valid, 0);
    check("reset_read_addr", mem_read_address, 0);
    check("reset_write_addr", mem_write_address, 0);
    check("reset_write_data", mem_write_data, 0);
    for (int i = 0; i < T; i++) check("reset_lsu_out", lsu_out[i], 0);
    reset = 1'b0;

    set_ops(16'd10, 16'd11, 16'd12, 16'd13, 16'd0, 16'd0, 16'd0, 16'd0);
    run_op(4'b1111, 1'b1, 1'b0, 0, 1'b0);
    check("dir_load_lane3", lsu_out[3], 113);

    set_ops(16'd5, 16'd6, 16'd7, 16'd8, 16'd50, 16'd60, 16'd70, 16'd80);
    run_op(4'b0101, 1'b0, 1'b1, 0, 1'b0);
    check("store_lane1_kept", lsu_out[1], 111);

    salt = data_t'(16'd99 - 16'd120);
    set_ops(16'd20, 16'd20, 16'd20, 16'd20, 16'd0, 16'd0, 16'd0, 16'd0);
    run_op(4'b1111, 1'b1, 1'b0, 0, 1'b0);
    check("coalesce_lane2", lsu_out[2], 99);

    run_op(4'b0000, 1'b1, 1'b0, 0, 1'b0);

    salt = 16'h0300;
    set_ops(16'h1234, 16'h0177, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0);
    run_op(4'b0010, 1'b1, 1'b0, 5, 1'b0);

    run_op(4'b1011, 1'b1, 1'b1, -1, 1'b0);
    run_op(4'b1100, 1'b1, 1'b0, 0, 1'b1);
    run_op(4'b0110, 1'b0, 1'b1, 1, 1'b1);

    reset_mid_wait();

    for (int k = 0; k < 4; k++) pool[k] = data_t'($urandom);
    for (int n = 0; n < 30; n++) begin
      m  = T'($urandom);
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      salt = data_t'($urandom);
      for (int i = 0; i < T; i++) begin
        rs1[i] = pool[$urandom_range(0, 3)];
        rs2[i] = data_t'($urandom);
      end
      run_op(m, rd, wr, -1, ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
